// File: rtl/shapes_pkg.sv
// -----------------------------------------------------------------------------
// shapes_pkg
// Shared types and constants for the shapes unit rasterizers.
//   circ_state_t : sequencer states of the midpoint circle rasterizer
//   D_STEP_NEG   : decision increment constant when d < 0   (d += 4x + 6)
//   D_STEP_POS   : decision increment constant when d >= 0  (d += 4(x-y) + 10)
//   D_INIT       : decision seed constant                   (d  = 3 - 2r)
// -----------------------------------------------------------------------------
package shapes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        STEP,
        DONE
    } circ_state_t;

    localparam int D_STEP_NEG = 6;
    localparam int D_STEP_POS = 10;
    localparam int D_INIT     = 3;

endpackage

// File: rtl/circle_decision_step.sv
// -----------------------------------------------------------------------------
// circle_decision_step
// Combinational midpoint decision update for one circle step. Uses the
// pre-update x/y.
//   d_i      : current signed decision variable (DW bits)
//   x_i, y_i : current unsigned coordinates (N bits)
//   d_next_o : updated decision variable
//   y_dec_o  : 1 when y must be decremented in this step (d_i >= 0)
// -----------------------------------------------------------------------------
module circle_decision_step
    import shapes_pkg::*;
#(
    parameter int N  = 10,
    parameter int DW = N + 3
) (
    input  logic signed [DW-1:0] d_i,
    input  logic        [N-1:0]  x_i,
    input  logic        [N-1:0]  y_i,
    output logic signed [DW-1:0] d_next_o,
    output logic                 y_dec_o
);

    // x and y are zero-extended so the 4x and 4(x-y) terms live at DW width.
    logic signed [DW-1:0] x_ext;
    logic signed [DW-1:0] y_ext;

    assign x_ext = {{(DW-N){1'b0}}, x_i};
    assign y_ext = {{(DW-N){1'b0}}, y_i};

    always_comb begin
        y_dec_o = ~d_i[DW-1];
        if (d_i[DW-1]) begin
            d_next_o = d_i + (x_ext <<< 2) + DW'(D_STEP_NEG);
        end else begin
            d_next_o = d_i + ((x_ext - y_ext) <<< 2) + DW'(D_STEP_POS);
        end
    end

endmodule

// File: rtl/circle_raster_seq.sv
// -----------------------------------------------------------------------------
// circle_raster_seq
// Midpoint circle rasterizer sequencer. Captures centre/radius on start, walks
// one octant with the decision variable, and streams the 8 symmetric pixels of
// every step over a valid/ready handshake.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : one-cycle request, honoured only in IDLE
//   cx, cy, r       : centre and radius, captured on accepted start
//   pix_ready       : downstream accepts the presented pixel
//   pix_valid       : pix_x/pix_y carry a valid pixel
//   pix_x, pix_y    : pixel coordinates, wrapping modulo 2^N
//   busy            : high from accepted start until DONE exits
//   done            : one-cycle pulse when the circle is finished
// -----------------------------------------------------------------------------
module circle_raster_seq
    import shapes_pkg::*;
#(
    parameter int N  = 10,
    parameter int DW = N + 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] cx,
    input  logic [N-1:0] cy,
    input  logic [N-1:0] r,
    input  logic         pix_ready,
    output logic         pix_valid,
    output logic [N-1:0] pix_x,
    output logic [N-1:0] pix_y,
    output logic         busy,
    output logic         done
);

    circ_state_t          state_q, state_d;
    logic [N-1:0]         cx_q, cx_d;
    logic [N-1:0]         cy_q, cy_d;
    logic [N-1:0]         x_q, x_d;
    logic [N-1:0]         y_q, y_d;
    logic signed [DW-1:0] d_q, d_d;
    logic [2:0]           oct_q, oct_d;

    logic signed [DW-1:0] r_ext;
    logic signed [DW-1:0] d_init;
    logic signed [DW-1:0] d_step;
    logic                 y_dec;

    assign r_ext  = {{(DW-N){1'b0}}, r};
    assign d_init = DW'(D_INIT) - (r_ext <<< 1);

    circle_decision_step #(
        .N  (N),
        .DW (DW)
    ) u_decision (
        .d_i      (d_q),
        .x_i      (x_q),
        .y_i      (y_q),
        .d_next_o (d_step),
        .y_dec_o  (y_dec)
    );

    // NOTE: every state/output variable gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x_d     = x_q;
        y_d     = y_q;
        d_d     = d_q;
        oct_d   = oct_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    x_d     = '0;
                    y_d     = r;
                    d_d     = d_init;
                    oct_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (pix_ready) begin
                    if (oct_q == 3'd7) begin
                        oct_d   = '0;
                        state_d = STEP;
                    end else begin
                        oct_d = oct_q + 3'd1;
                    end
                end
            end
            STEP: begin
                d_d = d_step;
                x_d = x_q + 1'b1;
                y_d = y_dec ? (y_q - 1'b1) : y_q;
                // y stepping below zero would wrap to a large unsigned value
                // and falsely keep the walk alive, so it ends the circle.
                if ((x_d <= y_d) && !(y_dec && (y_q == '0))) begin
                    state_d = EMIT;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            d_q     <= d_d;
            oct_q   <= oct_d;
        end
    end

    // Octant mux; pixel outputs are forced to zero outside EMIT so they read
    // 0 in reset and idle.
    always_comb begin
        pix_valid = (state_q == EMIT);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        pix_x     = '0;
        pix_y     = '0;
        if (state_q == EMIT) begin
            unique case (oct_q)
                3'd0: begin pix_x = cx_q + x_q; pix_y = cy_q + y_q; end
                3'd1: begin pix_x = cx_q - x_q; pix_y = cy_q + y_q; end
                3'd2: begin pix_x = cx_q + x_q; pix_y = cy_q - y_q; end
                3'd3: begin pix_x = cx_q - x_q; pix_y = cy_q - y_q; end
                3'd4: begin pix_x = cx_q + y_q; pix_y = cy_q + x_q; end
                3'd5: begin pix_x = cx_q - y_q; pix_y = cy_q + x_q; end
                3'd6: begin pix_x = cx_q + y_q; pix_y = cy_q - x_q; end
                3'd7: begin pix_x = cx_q - y_q; pix_y = cy_q - x_q; end
                default: begin pix_x = '0; pix_y = '0; end
            endcase
        end
    end

endmodule

// File: doc/circle_raster_seq.md
Name: circle_raster_seq

Overview:
Sequencer for the midpoint (Bresenham) circle rasterizer in the shapes unit. It accepts a centre and radius, iterates x/y and the decision variable, and applies the team's decision update: d += 4x+6 when d<0, otherwise d += 4(x-y)+10. It streams all 8 octant-symmetric pixels per step over a valid/ready handshake to the framebuffer writer.

Parameters:
N, 10, coordinate/radius width in bits (unsigned)
DW, N+3, signed width of decision variable d

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
cx  input  N  centre x, captured on accepted start
cy  input  N  centre y, captured on accepted start
r  input  N  radius, captured on accepted start
pix_ready  input  1  downstream accepts pixel this cycle
pix_valid  output  1  pix_x/pix_y hold a valid pixel
pix_x  output  N  pixel x, modulo 2^N
pix_y  output  N  pixel y, modulo 2^N
busy  output  1  high from accepted start until DONE exits
done  output  1  one-cycle pulse when the circle is finished

Behaviour:
- Reset (async, any state): state=IDLE; pix_valid=0, pix_x=0, pix_y=0, busy=0, done=0; x=0, y=0, d=0, oct=0.
- States: IDLE, EMIT, STEP, DONE.
- IDLE: on start=1, latch cx/cy/r; x=0, y=r, d=3-2r (sign-extended to DW); oct=0; go to EMIT. busy rises in the next cycle.
- EMIT: pix_valid=1 and pixel chosen by oct:
  - 0:(cx+x,cy+y)  1:(cx-x,cy+y)  2:(cx+x,cy-y)  3:(cx-x,cy-y)
  - 4:(cx+y,cy+x)  5:(cx-y,cy+x)  6:(cx+y,cy-x)  7:(cx-y,cy-x)
- EMIT handshake:
  - Transfer occurs when pix_valid && pix_ready.
  - While pix_ready=0, pix_x/pix_y/pix_valid stay stable.
  - On a transfer with oct<7: oct++.
  - On a transfer with oct==7: oct=0, go to STEP.
- STEP (1 cycle, pix_valid=0): compute with the pre-update x,y.
  - If d<0: d += 4x+6, x++.
  - Else: d += 4(x-y)+10, x++, y--.
  - Then, if new x <= new y (unsigned), go to EMIT; else go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE only.
- Duplicate pixels (x=0, x==y, r=0) are emitted, not suppressed; every step emits exactly 8 beats.
- Coordinate add/sub is N-bit, wrapping modulo 2^N. No clipping.
- d is signed DW-bit. 4x and 4(x-y) are formed at DW width, with x,y zero-extended.
- start while busy is ignored; no queueing.
- Throughput: 9 cycles per step with pix_ready held high.
- Latency: first pix_valid 1 cycle after the accepted start.

Decomposition:
- Package shapes_pkg holds:
  - typedef enum logic [1:0] {IDLE, EMIT, STEP, DONE} circ_state_t
  - localparam D_STEP_NEG=6, D_STEP_POS=10, D_INIT=3
- Sub-module circle_decision_step #(N,DW): combinational (d,x,y) -> (d_next, y_dec). It is instantiated once and used in STEP.
- Octant mux is inline.

Test Plan:
- r=0, cx=cy=100, pix_ready=1 -> 8 beats all (100,100); done pulses 9 cycles after first pix_valid; busy then drops.
- r=1, cx=cy=50 -> 8 beats: (50,51),(50,51),(50,49),(50,49),(51,50),(49,50),(51,50),(49,50); then done.
- r=3, cx=cy=20 -> exactly 24 beats. Steps: (x,y)=(0,3),(1,3),(2,2). d sequence: -3, 3, 5, 15.
- r=3 with pix_ready toggled 1-0-1 each cycle -> same 24 pixels, in the same order, with no loss or duplication; outputs stable while stalled.
- Reset asserted mid-EMIT at r=5 -> outputs 0, state IDLE immediately. A new start with r=1 then produces the r=1 sequence.
- cx=0, cy=0, r=2, N=10 -> first step emits (0,2),(0,2),(0,1022),(0,1022),(2,0),(1022,0),(2,0),(1022,0), showing coordinate wrap. A start pulsed while busy -> ignored.
